// File: rtl/fetch_queue_multi_if.sv
// Fetch-stage bundle: I-cache/memory request side, decoder drain side and redirect inputs.
// master = fetch stage, slave = surrounding pipeline/memory.
interface fetch_queue_multi_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int ADDR_W      = 32,
  parameter int INST_W      = 32
);
  logic                                 rdy;
  logic                                 reqEn;
  logic [FETCH_WIDTH*ADDR_W-1:0]        reqAddr;
  logic [FETCH_WIDTH-1:0]               cacheHit;
  logic [FETCH_WIDTH*INST_W-1:0]        cacheInst;
  logic                                 memValid;
  logic [INST_W-1:0]                    memInst;
  logic [$clog2(FETCH_WIDTH+1)-1:0]     deqNum;
  logic [FETCH_WIDTH-1:0]               decValid;
  logic [FETCH_WIDTH*ADDR_W-1:0]        decPC;
  logic [FETCH_WIDTH*INST_W-1:0]        decInst;
  logic                                 bjResolved;
  logic [ADDR_W-1:0]                    bjTarget;
  logic                                 mistaken;
  logic [ADDR_W-1:0]                    trueAddr;

  modport master (
    input  rdy,
    output reqEn, reqAddr,
    input  cacheHit, cacheInst, memValid, memInst,
    input  deqNum,
    output decValid, decPC, decInst,
    input  bjResolved, bjTarget, mistaken, trueAddr
  );

  modport slave (
    output rdy,
    input  reqEn, reqAddr,
    output cacheHit, cacheInst, memValid, memInst,
    output deqNum,
    input  decValid, decPC, decInst,
    output bjResolved, bjTarget, mistaken, trueAddr
  );
endinterface

// File: rtl/fetch_queue_multi.sv
// Superscalar fetch stage feeding a circular {pc, inst} queue drained by the decoder.
// Optional static JAL / backward-branch prediction: define FETCH_STATIC_PRED_EN.
module fetch_queue_multi #(
  parameter int FETCH_WIDTH = 2,
  parameter int QUEUE_DEPTH = 8,
  parameter int ADDR_W      = 32,
  parameter int INST_W      = 32
) (
  input logic                clk,
  input logic                rst,
  fetch_queue_multi_if.master bus
);
  localparam int K_W   = $clog2(FETCH_WIDTH + 1);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_BJ} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] q_pc   [QUEUE_DEPTH];
  logic [INST_W-1:0] q_inst [QUEUE_DEPTH];

  logic              req_en;
  logic [ADDR_W-1:0] lane_pc   [FETCH_WIDTH];
  logic [INST_W-1:0] lane_inst [FETCH_WIDTH];
  logic [K_W-1:0]    acc_k, deq_k;
  logic              bj_hit;
  logic              scan_stop;

`ifdef FETCH_STATIC_PRED_EN
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  logic [ADDR_W-1:0] bj_pc, j_imm, b_imm, pred_target;
  logic [INST_W-1:0] bj_inst;
  logic              pred_taken;
`endif

  // Free-slot guard uses the registered count only, so a full queue can never overflow.
  assign req_en = (state == FETCH)
               && (count <= CNT_W'(QUEUE_DEPTH - FETCH_WIDTH))
               && !bus.mistaken;

  // Lane 0 takes the memory instruction whenever the cache missed on it.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_pc[i]   = pc + ADDR_W'(4 * i);
      lane_inst[i] = bus.cacheInst[i*INST_W +: INST_W];
    end
    if (!bus.cacheHit[0]) lane_inst[0] = bus.memInst;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    acc_k     = '0;
    bj_hit    = 1'b0;
    scan_stop = 1'b0;
`ifdef FETCH_STATIC_PRED_EN
    bj_pc     = '0;
    bj_inst   = '0;
`endif
    if (req_en) begin
      if (bus.cacheHit[0]) begin
        // NOTE: blocking '=' in combinational logic: later iterations must see scan_stop
        // as updated by earlier ones within the same evaluation.
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          if (!scan_stop) begin
            if (bus.cacheHit[i]) begin
              acc_k = K_W'(i + 1);
              if (lane_inst[i][6]) begin
                scan_stop = 1'b1;
                bj_hit    = 1'b1;
`ifdef FETCH_STATIC_PRED_EN
                bj_pc     = lane_pc[i];
                bj_inst   = lane_inst[i];
`endif
              end
            end else begin
              scan_stop = 1'b1;
            end
          end
        end
      end else if (bus.memValid) begin
        acc_k  = K_W'(1);
        bj_hit = lane_inst[0][6];
`ifdef FETCH_STATIC_PRED_EN
        bj_pc   = lane_pc[0];
        bj_inst = lane_inst[0];
`endif
      end
    end
  end

`ifdef FETCH_STATIC_PRED_EN
  always_comb begin
    j_imm = {{(ADDR_W-21){bj_inst[31]}}, bj_inst[31], bj_inst[19:12], bj_inst[20],
             bj_inst[30:21], 1'b0};
    b_imm = {{(ADDR_W-13){bj_inst[31]}}, bj_inst[31], bj_inst[7], bj_inst[30:25],
             bj_inst[11:8], 1'b0};
    pred_taken  = bj_hit && ((bj_inst[6:0] == OP_JAL)
                          || ((bj_inst[6:0] == OP_BRANCH) && bj_inst[31]));
    pred_target = (bj_inst[6:0] == OP_JAL) ? bj_pc + j_imm : bj_pc + b_imm;
  end
`endif

  assign deq_k = (CNT_W'(bus.deqNum) > count) ? K_W'(count) : bus.deqNum;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (bus.mistaken) begin
      state_nxt = FETCH;
      pc_nxt    = bus.trueAddr;
    end else begin
      case (state)
        IDLE:    state_nxt = FETCH;
        FETCH: begin
          if (acc_k != '0) begin
            pc_nxt = pc + (ADDR_W'(acc_k) << 2);
            if (bj_hit) state_nxt = WAIT_BJ;
`ifdef FETCH_STATIC_PRED_EN
            if (pred_taken) begin
              pc_nxt    = pred_target;
              state_nxt = FETCH;
            end
`endif
          end
        end
        WAIT_BJ: begin
          if (bus.bjResolved) begin
            pc_nxt    = bus.bjTarget;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.rdy) begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (bus.mistaken) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + PTR_W'(deq_k);
        tail  <= tail + PTR_W'(acc_k);
        count <= count + CNT_W'(acc_k) - CNT_W'(deq_k);
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; count alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (!rst && bus.rdy) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (K_W'(i) < acc_k) begin
          q_pc[tail + PTR_W'(i)]   <= lane_pc[i];
          q_inst[tail + PTR_W'(i)] <= lane_inst[i];
        end
      end
    end
  end

  assign bus.reqEn = req_en;

  always_comb begin
    bus.reqAddr  = '0;
    bus.decValid = '0;
    bus.decPC    = '0;
    bus.decInst  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      bus.reqAddr[i*ADDR_W +: ADDR_W] = lane_pc[i];
      bus.decValid[i]                 = !bus.mistaken && (CNT_W'(i) < count);
      bus.decPC[i*ADDR_W +: ADDR_W]   = q_pc[head + PTR_W'(i)];
      bus.decInst[i*INST_W +: INST_W] = q_inst[head + PTR_W'(i)];
    end
  end
endmodule

// File: tb/tb_fetch_queue_multi.sv
// Directed scenarios followed by random traffic, checked against a queue-based model
// of the fetch stage (default build, static prediction disabled).
module tb_fetch_queue_multi;
  localparam int FW = 2;
  localparam int QD = 8;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int KW = $clog2(FW + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_multi_if #(.FETCH_WIDTH(FW), .ADDR_W(AW), .INST_W(IW)) bus ();

  fetch_queue_multi #(
    .FETCH_WIDTH(FW), .QUEUE_DEPTH(QD), .ADDR_W(AW), .INST_W(IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } entry_t;
  typedef enum int {M_IDLE, M_FETCH, M_WAIT} mode_t;

  entry_t        mq[$];
  mode_t         m_mode = M_IDLE;
  logic [AW-1:0] m_pc   = '0;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_req();
    return (m_mode == M_FETCH) && ((QD - mq.size()) >= FW) && !bus.mistaken;
  endfunction

  function automatic logic [IW-1:0] plain_inst(input logic [AW-1:0] a);
    return {a[24:0], 7'h13};
  endfunction

  task automatic idle_inputs();
    bus.rdy        = 1'b1;
    bus.cacheHit   = '0;
    bus.cacheInst  = '0;
    bus.memValid   = 1'b0;
    bus.memInst    = '0;
    bus.deqNum     = '0;
    bus.bjResolved = 1'b0;
    bus.bjTarget   = '0;
    bus.mistaken   = 1'b0;
    bus.trueAddr   = '0;
  endtask

  task automatic drive_fetch(input logic [FW-1:0] hit, input int bj_lane);
    bus.cacheHit = hit;
    for (int i = 0; i < FW; i++)
      bus.cacheInst[i*IW +: IW] = (i == bj_lane) ? 32'h0000_0063 : plain_inst(m_pc + AW'(4 * i));
  endtask

  // Compares all DUT outputs against the model; decode data only on lanes expected valid.
  task automatic cyc_check();
    logic [FW*AW-1:0] e_addr, e_pc, o_pc;
    logic [FW*IW-1:0] e_inst, o_inst;
    logic [FW-1:0]    e_dv;
    #1;
    e_addr = '0; e_pc = '0; o_pc = '0; e_inst = '0; o_inst = '0; e_dv = '0;
    for (int i = 0; i < FW; i++) begin
      e_addr[i*AW +: AW] = m_pc + AW'(4 * i);
      if (!bus.mistaken && i < mq.size()) begin
        e_dv[i]            = 1'b1;
        e_pc[i*AW +: AW]   = mq[i].pc;
        e_inst[i*IW +: IW] = mq[i].inst;
        o_pc[i*AW +: AW]   = bus.decPC[i*AW +: AW];
        o_inst[i*IW +: IW] = bus.decInst[i*IW +: IW];
      end
    end
    check("reqEn",    bus.reqEn,    exp_req());
    check("reqAddr",  bus.reqAddr,  e_addr);
    check("decValid", bus.decValid, e_dv);
    check("decPC",    o_pc,         e_pc);
    check("decInst",  o_inst,       e_inst);
  endtask

  // Advances the model by one clock using the inputs currently driven, then clocks the DUT.
  task automatic cyc_adv();
    logic          go, bj;
    int            d, k;
    logic [IW-1:0] ins;
    if (rst) begin
      mq.delete();
      m_pc   = '0;
      m_mode = M_IDLE;
    end else if (bus.rdy) begin
      if (bus.mistaken) begin
        mq.delete();
        m_pc   = bus.trueAddr;
        m_mode = M_FETCH;
      end else begin
        go = exp_req();
        d  = (int'(bus.deqNum) < mq.size()) ? int'(bus.deqNum) : mq.size();
        repeat (d) void'(mq.pop_front());
        k  = 0;
        bj = 1'b0;
        if (go) begin
          if (bus.cacheHit[0]) begin
            for (int i = 0; i < FW; i++) begin
              if (!bus.cacheHit[i]) break;
              ins = bus.cacheInst[i*IW +: IW];
              mq.push_back('{pc: m_pc + AW'(4 * i), inst: ins});
              k++;
              if (ins[6]) begin
                bj = 1'b1;
                break;
              end
            end
          end else if (bus.memValid) begin
            mq.push_back('{pc: m_pc, inst: bus.memInst});
            k  = 1;
            bj = bus.memInst[6];
          end
        end
        case (m_mode)
          M_IDLE:  m_mode = M_FETCH;
          M_FETCH: begin
            m_pc = m_pc + AW'(4 * k);
            if (bj) m_mode = M_WAIT;
          end
          M_WAIT: begin
            if (bus.bjResolved) begin
              m_pc   = bus.bjTarget;
              m_mode = M_FETCH;
            end
          end
          default: m_mode = M_IDLE;
        endcase
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    cyc_check();
    check("rst_reqEn",    bus.reqEn,    1'b0);
    check("rst_decValid", bus.decValid, 2'b00);
    check("rst_reqAddr",  bus.reqAddr,  64'h0000_0004_0000_0000);
    cyc_adv();
    rst = 1'b0;

    // IDLE -> FETCH
    cyc_check();
    check("idle_reqEn", bus.reqEn, 1'b0);
    cyc_adv();

    // Dual-hit streaming, pc 0, 8, 16, 24
    bus.deqNum = KW'(2);
    for (int n = 0; n < 4; n++) begin
      drive_fetch(2'b11, -1);
      cyc_check();
      check("stream_addr", bus.reqAddr[AW-1:0], AW'(8 * n));
      check("stream_decValid", bus.decValid, (n > 0) ? 2'b11 : 2'b00);
      if (n > 0) check("stream_decPC", bus.decPC, {AW'(8 * n - 4), AW'(8 * n - 8)});
      cyc_adv();
    end

    // Partial hit at 0x20
    drive_fetch(2'b01, -1);
    cyc_check();
    check("partial_addr", bus.reqAddr[AW-1:0], 32'h20);
    cyc_adv();

    // Miss served by memory at 0x24, then a miss with no memory response
    bus.cacheHit = '0;
    bus.memValid = 1'b1;
    bus.memInst  = 32'h0000_0013;
    cyc_check();
    check("after_partial_addr", bus.reqAddr[AW-1:0], 32'h24);
    check("after_partial_valid", bus.decValid, 2'b01);
    cyc_adv();
    bus.memValid = 1'b0;
    cyc_check();
    check("mem_addr", bus.reqAddr[AW-1:0], 32'h28);
    cyc_adv();
    cyc_check();
    check("retry_reqEn", bus.reqEn, 1'b1);
    check("retry_addr", bus.reqAddr[AW-1:0], 32'h28);
    cyc_adv();

    // Stream up to 0x40
    for (int n = 0; n < 8 && m_pc != 32'h40; n++) begin
      drive_fetch(2'b11, -1);
      cyc_check();
      cyc_adv();
    end

    // Branch in lane 0 at 0x40
    drive_fetch(2'b11, 0);
    cyc_check();
    check("br_addr", bus.reqAddr[AW-1:0], 32'h40);
    cyc_adv();
    drive_fetch(2'b11, -1);
    cyc_check();
    check("br_wait_reqEn", bus.reqEn, 1'b0);
    check("br_decValid", bus.decValid, 2'b01);
    check("br_decPC", bus.decPC[AW-1:0], 32'h40);
    check("br_decInst", bus.decInst[IW-1:0], 32'h63);
    cyc_adv();
    bus.bjResolved = 1'b1;
    bus.bjTarget   = 32'h100;
    cyc_check();
    check("br_hold_reqEn", bus.reqEn, 1'b0);
    cyc_adv();
    bus.bjResolved = 1'b0;
    cyc_check();
    check("br_target_addr", bus.reqAddr[AW-1:0], 32'h100);
    check("br_target_reqEn", bus.reqEn, 1'b1);
    cyc_adv();

    // Fill to QUEUE_DEPTH-1 with no dequeue
    bus.deqNum = '0;
    drive_fetch(2'b01, -1);
    cyc_check();
    cyc_adv();
    for (int n = 0; n < 10; n++) begin
      drive_fetch(2'b11, -1);
      cyc_check();
      if (!exp_req()) break;
      cyc_adv();
    end
    check("full_reqEn", bus.reqEn, 1'b0);
    check("full_decValid", bus.decValid, 2'b11);
    cyc_adv();
    bus.deqNum = KW'(2);
    cyc_check();
    check("full_still_reqEn", bus.reqEn, 1'b0);
    cyc_adv();
    cyc_check();
    check("drain_reqEn", bus.reqEn, 1'b1);
    cyc_adv();
    for (int n = 0; n < 8; n++) begin
      drive_fetch(2'b11, -1);
      cyc_check();
      cyc_adv();
    end

    // Settle at count 5, then redirect with simultaneous enqueue and dequeue
    for (int n = 0; n < 20 && mq.size() != 5; n++) begin
      if (mq.size() > 5) begin
        bus.deqNum = KW'(1);
        drive_fetch(2'b00, -1);
      end else begin
        bus.deqNum = '0;
        drive_fetch(2'b01, -1);
      end
      cyc_check();
      cyc_adv();
    end
    drive_fetch(2'b11, -1);
    bus.deqNum   = KW'(1);
    bus.mistaken = 1'b1;
    bus.trueAddr = 32'h200;
    cyc_check();
    check("redir_decValid", bus.decValid, 2'b00);
    check("redir_reqEn", bus.reqEn, 1'b0);
    cyc_adv();
    bus.mistaken = 1'b0;
    cyc_check();
    check("redir_addr", bus.reqAddr[AW-1:0], 32'h200);
    check("redir_empty", bus.decValid, 2'b00);
    cyc_adv();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [IW-1:0] r;
      rst            = ($urandom_range(299) == 0);
      bus.rdy        = ($urandom_range(9) != 0);
      bus.mistaken   = ($urandom_range(39) == 0);
      bus.trueAddr   = AW'($urandom) & ~32'h3;
      bus.bjResolved = ($urandom_range(3) == 0);
      bus.bjTarget   = AW'($urandom) & ~32'h3;
      bus.deqNum     = KW'($urandom_range((1 << KW) - 1));
      bus.cacheHit   = ($urandom_range(3) != 0) ? {FW{1'b1}} : FW'($urandom);
      for (int i = 0; i < FW; i++) begin
        r    = $urandom;
        r[6] = ($urandom_range(7) == 0);
        bus.cacheInst[i*IW +: IW] = r;
      end
      bus.memValid = $urandom_range(1) == 1;
      r            = $urandom;
      r[6]         = ($urandom_range(7) == 0);
      bus.memInst  = r;
      cyc_check();
      cyc_adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue_multi.md
Name: fetch_queue_multi

Overview:
- Parametrised superscalar front-end fetch stage: issues FETCH_WIDTH consecutive instruction addresses per cycle to the I-cache.
- Falls back to a single-instruction memory path on a lane-0 miss.
- Buffers fetched {pc, inst} pairs in a circular queue that the decoder drains up to FETCH_WIDTH per cycle.
- Stops fetching after any branch/jump until the target resolves; a mispredict redirect flushes the queue.

Parameters:
- FETCH_WIDTH, 2, instructions requested/accepted/dequeued per cycle (1..4).
- QUEUE_DEPTH, 8, queue entries; power of two, >= 2*FETCH_WIDTH.
- ADDR_W, 32, PC width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global enable; when low, all state holds.
- reqEn  out  1  I-cache/memory request valid.
- reqAddr  out  FETCH_WIDTH*ADDR_W  lane i = pc+4*i, lane 0 in LSBs.
- cacheHit  in  FETCH_WIDTH  per-lane hit, same cycle as reqEn.
- cacheInst  in  FETCH_WIDTH*INST_W  per-lane instruction.
- memValid  in  1  memory returns the lane-0 instruction.
- memInst  in  INST_W  memory instruction.
- deqNum  in  $clog2(FETCH_WIDTH+1)  entries the decoder takes this cycle.
- decValid  out  FETCH_WIDTH  lane i holds a valid queue entry.
- decPC  out  FETCH_WIDTH*ADDR_W  head+i PCs.
- decInst  out  FETCH_WIDTH*INST_W  head+i instructions.
- bjResolved  in  1  control-flow target known.
- bjTarget  in  ADDR_W  resolved target.
- mistaken  in  1  mispredict redirect.
- trueAddr  in  ADDR_W  redirect PC.

Behaviour:
- Reset values:
  - state=IDLE, pc=0, head=tail=count=0.
  - reqEn=0, decValid=0, reqAddr = lane addresses of pc=0.
- States: IDLE, FETCH, WAIT_BJ.
  - IDLE -> FETCH unconditionally on the next rdy cycle.
- reqEn = (state==FETCH) & (QUEUE_DEPTH-count >= FETCH_WIDTH) & ~mistaken. Uses the registered count only.
- BJ test: inst[6]==1.
- Accept count k, computed only when reqEn=1:
  - If cacheHit[0]: k = number of contiguous hit lanes from lane 0, truncated after the first BJ lane (that lane is included).
  - Else if memValid: k=1 using memInst.
  - Else k=0; retry the same pc next cycle.
- On k>0:
  - Enqueue k entries in lane order at tail.
  - pc <= pc + 4*k.
  - If any accepted entry is BJ: state <= WAIT_BJ (reqEn drops next cycle).
- WAIT_BJ:
  - On bjResolved: pc <= bjTarget, state <= FETCH.
  - Otherwise hold. Dequeue continues.
- Dequeue:
  - decValid[i] = (i < count); outputs are combinational from head+i modulo depth.
  - Dequeue d = min(deqNum, count).
  - Simultaneous enq/deq: count <= count + k - d.
  - head/tail wrap modulo QUEUE_DEPTH.
- Full: never overflows, by construction of the reqEn guard. A deqNum larger than count is clipped. Empty: decValid=0.
- mistaken (highest priority, any state):
  - head=tail=count <= 0, pc <= trueAddr, state <= FETCH.
  - Same-cycle enqueue, dequeue and bjResolved are discarded.
  - decValid forced to 0 that cycle.
- rst mid-operation: returns to reset values next edge. In-flight responses are ignored.
- rdy=0: no state update. Outputs still reflect the held state.

Optional Feature:
- Macro: FETCH_STATIC_PRED_EN.
- Defined:
  - A JAL lane (opcode 1101111) redirects immediately: pc <= lane pc + J-imm. Lanes after it are dropped, no WAIT_BJ.
  - A conditional branch (1100011) with negative B-imm is predicted taken: pc <= lane pc + B-imm, no WAIT_BJ.
  - Other BJ instructions behave as without the macro.
  - Wrong predictions are corrected only via mistaken.
- Undefined: every BJ enters WAIT_BJ.

Test Plan:
- Dual-hit streaming: FETCH_WIDTH=2, all hits, non-BJ, deqNum=2 -> pc advances 0,8,16; decPC pairs (0,4),(8,12); count stays bounded.
- Partial hit: cacheHit=2'b01 at pc=0x20 -> k=1, one entry enqueued, next reqAddr lane0=0x24.
- Miss plus memory: cacheHit=0, memValid=1, memInst=0x00000013 -> one entry enqueued, pc+=4; with memValid=0 -> reqEn held, pc unchanged.
- Branch in lane 0: lane0 inst=0x00000063 at pc=0x40 -> only lane 0 enqueued, state WAIT_BJ, reqEn=0; bjResolved with bjTarget=0x100 -> next reqAddr lane0=0x100.
- Full/wrap: deqNum=0 until count=QUEUE_DEPTH-1 -> reqEn=0; then deqNum=2 -> reqEn reasserts; tail wraps to 0 and data is intact.
- Redirect with simultaneous traffic: count=5 with enqueue and dequeue in the same cycle as mistaken, trueAddr=0x200 -> count=0, decValid=0, next reqAddr lane0=0x200.
